spi_arb: RTL and testbench



---
 rtl/spi_arb_pkg.sv | 17 +
 rtl/spi_arb_rr_pick.sv | 29 ++
 rtl/spi_arb.sv | 152 +++++++++++++++
 tb/tb_spi_arb.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_arb_pkg.sv
// Shared types and constants for the SPI monarch arbiter.
package spi_arb_pkg;

    localparam int CMD_W = 16;

    // err qualifier values carried alongside ack
    localparam logic ERR_NONE = 1'b0;
    localparam logic ERR_TO   = 1'b1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LAUNCH = 2'd1,
        WAIT   = 2'd2,
        GAP    = 2'd3
    } state_t;

endpackage

// File: rtl/spi_arb_rr_pick.sv
// Combinational round-robin selector: first set request after last_gnt, with wrap.
module rr_pick #(
    parameter int N = 4
) (
    input  logic [N-1:0]         req_i,
    input  logic [$clog2(N)-1:0] last_gnt_i,
    output logic                 any_o,
    output logic [$clog2(N)-1:0] winner_o
);

    localparam int IW = $clog2(N);

    logic [IW-1:0] cand;

    // Scan from the farthest candidate to the nearest so the nearest set bit wins.
    always_comb begin
        any_o    = 1'b0;
        winner_o = '0;
        cand     = '0;
        for (int k = N; k >= 1; k--) begin
            cand = IW'((int'(last_gnt_i) + k) % N);
            if (req_i[cand]) begin
                any_o    = 1'b1;
                winner_o = cand;
            end
        end
    end

endmodule

// File: rtl/spi_arb.sv
// Round-robin arbiter/sequencer sharing one 16-bit SPI monarch among NUM_REQ requesters.
// Handshake: req is a level held until its one-cycle ack; err qualifies ack (1 = timed out,
// resp_out not updated); snd is a one-cycle launch with cmd stable; done is a level whose
// rising edge marks completion.
module spi_arb
    import spi_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int GAP_CYC = 2,
    parameter int TO_CYC  = 2048
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_REQ-1:0]       req_i,
    input  logic [CMD_W*NUM_REQ-1:0] req_cmd_i,
    output logic [NUM_REQ-1:0]       ack_o,
    output logic                     err_o,
    output logic [CMD_W-1:0]         resp_out_o,
    output logic                     busy_o,
    output logic [2:0]               owner_o,
    output logic                     snd_o,
    output logic [CMD_W-1:0]         cmd_o,
    input  logic                     done_i,
    input  logic [CMD_W-1:0]         resp_i,
    output state_t                   state_o
);

    localparam int IW    = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(TO_CYC + GAP_CYC + 1);
    localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TO_CYC - 1);
    // GAP always lasts at least one cycle; GAP_CYC of 0 or 1 both leave after one.
    localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'((GAP_CYC == 0) ? 0 : GAP_CYC - 1);

    state_t               state_q, state_d;
    logic [IW-1:0]        owner_q, owner_d;
    logic [IW-1:0]        last_gnt_q, last_gnt_d;
    logic [CMD_W-1:0]     cmd_q, cmd_d;
    logic [CMD_W-1:0]     resp_q, resp_d;
    logic [NUM_REQ-1:0]   ack_q, ack_d;
    logic                 err_q, err_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 done_q;

    logic                 pick_any;
    logic [IW-1:0]        pick_idx;
    logic                 done_edge;
    logic [CMD_W-1:0]     cmd_arr [NUM_REQ];

    rr_pick #(.N(NUM_REQ)) u_pick (
        .req_i      (req_i),
        .last_gnt_i (last_gnt_q),
        .any_o      (pick_any),
        .winner_o   (pick_idx)
    );

    // Unpack the flat command bus into one word per requester.
    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            cmd_arr[i] = req_cmd_i[i*CMD_W +: CMD_W];
        end
    end

    // Only a fresh rising edge of done counts; a level left from a prior transaction does not.
    assign done_edge = done_i & ~done_q;

    // Next-state and datapath updates; ack/err default low so they pulse for one cycle.
    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        last_gnt_d = last_gnt_q;
        cmd_d      = cmd_q;
        resp_d     = resp_q;
        cnt_d      = cnt_q;
        ack_d      = '0;
        err_d      = ERR_NONE;
        case (state_q)
            IDLE: begin
                if (pick_any) begin
                    owner_d = pick_idx;
                    cmd_d   = cmd_arr[pick_idx];
                    state_d = LAUNCH;
                end
            end
            LAUNCH: begin
                cnt_d   = '0;
                state_d = WAIT;
            end
            WAIT: begin
                if (done_edge) begin
                    resp_d         = resp_i;
                    ack_d[owner_q] = 1'b1;
                    err_d          = ERR_NONE;
                    last_gnt_d     = owner_q;
                    cnt_d          = '0;
                    state_d        = GAP;
                end else if (cnt_q == TO_LAST) begin
                    ack_d[owner_q] = 1'b1;
                    err_d          = ERR_TO;
                    last_gnt_d     = owner_q;
                    cnt_d          = '0;
                    state_d        = GAP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            GAP: begin
                if (cnt_q >= GAP_LAST) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            owner_q    <= '0;
            last_gnt_q <= IW'(NUM_REQ - 1);
            cmd_q      <= '0;
            resp_q     <= '0;
            ack_q      <= '0;
            err_q      <= ERR_NONE;
            cnt_q      <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            last_gnt_q <= last_gnt_d;
            cmd_q      <= cmd_d;
            resp_q     <= resp_d;
            ack_q      <= ack_d;
            err_q      <= err_d;
            cnt_q      <= cnt_d;
            done_q     <= done_i;
        end
    end

    assign snd_o      = (state_q == LAUNCH);
    assign busy_o     = (state_q != IDLE);
    assign cmd_o      = cmd_q;
    assign resp_out_o = resp_q;
    assign ack_o      = ack_q;
    assign err_o      = err_q;
    assign owner_o    = 3'(owner_q);
    assign state_o    = state_q;

endmodule

// File: tb/tb_spi_arb.sv
// Self-checking bench for spi_arb: vector table plus hand-written corner sequences.
module tb_spi_arb;
    import spi_arb_pkg::*;

    localparam int NUM_REQ = 4;
    localparam int GAP_CYC = 2;
    localparam int TO_CYC  = 20;

    logic                     clk = 1'b0;
    logic                     rst_n = 1'b0;
    logic [NUM_REQ-1:0]       req_i = '0;
    logic [CMD_W*NUM_REQ-1:0] req_cmd_i = {16'h0F0F, 16'h3C3C, 16'hA5C3, 16'h5A01};
    logic [NUM_REQ-1:0]       ack_o;
    logic                     err_o;
    logic [CMD_W-1:0]         resp_out_o;
    logic                     busy_o;
    logic [2:0]               owner_o;
    logic                     snd_o;
    logic [CMD_W-1:0]         cmd_o;
    logic                     done_i = 1'b0;
    logic [CMD_W-1:0]         resp_i = '0;
    state_t                   state_w;

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;

    // monarch model controls
    logic [CMD_W-1:0] mon_resp   = '0;
    logic             mon_hang   = 1'b0;
    int               stale_hold = 0;
    int               mon_lat    = 3;
    int               rise_cyc   = 0;

    spi_arb #(.NUM_REQ(NUM_REQ), .GAP_CYC(GAP_CYC), .TO_CYC(TO_CYC)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_i      (req_i),
        .req_cmd_i  (req_cmd_i),
        .ack_o      (ack_o),
        .err_o      (err_o),
        .resp_out_o (resp_out_o),
        .busy_o     (busy_o),
        .owner_o    (owner_o),
        .snd_o      (snd_o),
        .cmd_o      (cmd_o),
        .done_i     (done_i),
        .resp_i     (resp_i),
        .state_o    (state_w)
    );

    // clock / reset block
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation still running, required to finish");
        $fatal(1, "global timeout");
    end

    // monarch model: clears done on snd (or after a stale hold), raises it mon_lat cycles later
    initial begin
        int phase;
        int cnt;
        phase = 0;
        cnt   = 0;
        forever begin
            @(posedge clk);
            #1;
            if (!rst_n) begin
                done_i = 1'b0;
                phase  = 0;
            end else if (snd_o) begin
                if (mon_hang) begin
                    done_i = 1'b0;
                    phase  = 0;
                end else if (stale_hold > 0) begin
                    phase = 1;
                    cnt   = stale_hold;
                end else begin
                    done_i = 1'b0;
                    phase  = 2;
                    cnt    = mon_lat;
                end
            end else if (phase == 1) begin
                cnt = cnt - 1;
                if (cnt == 0) begin
                    done_i = 1'b0;
                    phase  = 2;
                    cnt    = mon_lat;
                end
            end else if (phase == 2) begin
                cnt = cnt - 1;
                if (cnt == 0) begin
                    done_i   = 1'b1;
                    resp_i   = mon_resp;
                    rise_cyc = cyc;
                    phase    = 0;
                end
            end
        end
    end

    // every cycle: at most one ack bit, err only alongside ack, no snd while in WAIT
    always @(negedge clk) begin
        if (rst_n) begin
            n_cmp++;
            if ($countones(ack_o) > 1 || (err_o && ack_o == '0) || (snd_o && state_w == WAIT)) begin
                n_fail++;
                $display("FAIL protocol: ack=%b err=%b snd=%b state=%0d, required one-hot ack, err with ack, no snd in WAIT",
                         ack_o, err_o, snd_o, state_w);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic bound_fail(input string nm);
        n_cmp++;
        n_fail++;
        $display("FAIL %s: event did not occur within its cycle budget (cycle %0d)", nm, cyc);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy_o && n < 60) begin
            tick();
            n++;
        end
        if (busy_o) bound_fail("idle_timeout");
    endtask

    task automatic wait_snd(output int c);
        c = -1;
        for (int i = 0; i < 60; i++) begin
            tick();
            if (snd_o) begin
                c = cyc;
                break;
            end
        end
        if (c < 0) bound_fail("snd_timeout");
    endtask

    task automatic wait_ack(output int c);
        c = -1;
        for (int i = 0; i < TO_CYC + 40; i++) begin
            tick();
            if (ack_o != '0) begin
                c = cyc;
                break;
            end
        end
        if (c < 0) bound_fail("ack_timeout");
    endtask

    // one full transaction applied from IDLE, checked end to end
    task automatic run_txn(input logic [3:0] pat, input int exp_own, input logic [15:0] exp_cmd,
                           input logic [15:0] rsp, input logic [15:0] exp_resp, input logic exp_err,
                           input logic withdraw);
        int snd_c;
        int ack_c;
        wait_idle();
        mon_resp = rsp;
        req_i    = pat;
        tick();
        check("snd_lat", 32'(snd_o), 32'd1);
        snd_c = cyc;
        check("owner", 32'(owner_o), 32'(exp_own));
        check("cmd", 32'(cmd_o), 32'(exp_cmd));
        if (withdraw) begin
            tick();
            req_i = '0;
        end
        wait_ack(ack_c);
        if (ack_c >= 0) begin
            check("ack", 32'(ack_o), 32'(4'b0001 << exp_own));
            check("err", 32'(err_o), 32'(exp_err));
            check("resp_out", 32'(resp_out_o), 32'(exp_resp));
            if (exp_err) check("to_lat", 32'(ack_c - snd_c), 32'(TO_CYC + 1));
            else         check("ack_lat", 32'(ack_c), 32'(rise_cyc + 1));
        end
        req_i = '0;
        tick();
        check("ack_pulse", 32'(ack_o), 32'd0);
        check("cmd_hold", 32'(cmd_o), 32'(exp_cmd));
    endtask

    typedef struct {
        logic [3:0]  req;
        int          own;
        logic [15:0] cmd;
        logic [15:0] rsp;
    } vec_t;

    vec_t vecs [8];

    initial begin
        int ack_prev;
        int snd_c;
        int ack_c;
        int own;

        // round-robin pointer starts at 3 after reset; owners derived by hand
        vecs[0] = '{4'b0010, 1, 16'hA5C3, 16'h1234};
        vecs[1] = '{4'b1111, 2, 16'h3C3C, 16'hBEEF};
        vecs[2] = '{4'b1011, 3, 16'h0F0F, 16'h0001};
        vecs[3] = '{4'b0110, 1, 16'hA5C3, 16'h8000};
        vecs[4] = '{4'b0001, 0, 16'h5A01, 16'hFFFF};
        vecs[5] = '{4'b1001, 3, 16'h0F0F, 16'h7E7E};
        vecs[6] = '{4'b1000, 3, 16'h0F0F, 16'h4242};
        vecs[7] = '{4'b0101, 0, 16'h5A01, 16'h1357};

        // reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_ack", 32'(ack_o), 32'd0);
        check("rst_err", 32'(err_o), 32'd0);
        check("rst_resp", 32'(resp_out_o), 32'd0);
        check("rst_busy", 32'(busy_o), 32'd0);
        check("rst_owner", 32'(owner_o), 32'd0);
        check("rst_snd", 32'(snd_o), 32'd0);
        check("rst_cmd", 32'(cmd_o), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // vector table
        for (int v = 0; v < 8; v++) begin
            run_txn(vecs[v].req, vecs[v].own, vecs[v].cmd, vecs[v].rsp, vecs[v].rsp, 1'b0, 1'b0);
        end

        // stale done: done stays high into WAIT, ack only on the later rising edge
        stale_hold = 4;
        run_txn(4'b0100, 2, 16'h3C3C, 16'h2468, 16'h2468, 1'b0, 1'b0);
        stale_hold = 0;

        // withdrawn request: req drops after grant, transaction still completes
        run_txn(4'b0100, 2, 16'h3C3C, 16'h9ABC, 16'h9ABC, 1'b0, 1'b1);

        // timeout: no done, err ack, resp_out keeps the last good response
        mon_hang = 1'b1;
        run_txn(4'b0110, 1, 16'hA5C3, 16'hDEAD, 16'h9ABC, 1'b1, 1'b0);
        mon_hang = 1'b0;
        run_txn(4'b0100, 2, 16'h3C3C, 16'h0F1E, 16'h0F1E, 1'b0, 1'b0);

        // reset in the middle of WAIT
        wait_idle();
        mon_hang = 1'b1;
        req_i    = 4'b1000;
        wait_snd(snd_c);
        check("pre_rst_owner", 32'(owner_o), 32'd3);
        repeat (3) tick();
        check("pre_rst_state", 32'(state_w), 32'(WAIT));
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_busy", 32'(busy_o), 32'd0);
        check("mid_rst_owner", 32'(owner_o), 32'd0);
        check("mid_rst_cmd", 32'(cmd_o), 32'd0);
        check("mid_rst_resp", 32'(resp_out_o), 32'd0);
        check("mid_rst_ack", 32'(ack_o), 32'd0);
        check("mid_rst_snd", 32'(snd_o), 32'd0);
        req_i    = '0;
        mon_hang = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // contention after reset: order 0,1,2,3,0 with a fixed gap between ack and next snd
        req_i    = 4'b1111;
        ack_prev = -1;
        for (int k = 0; k < 5; k++) begin
            own      = k % NUM_REQ;
            mon_resp = 16'(16'hC000 + k);
            wait_snd(snd_c);
            check("rr_owner", 32'(owner_o), 32'(own));
            if (ack_prev >= 0 && snd_c >= 0) check("grant_gap", 32'(snd_c - ack_prev), 32'(GAP_CYC + 1));
            wait_ack(ack_c);
            if (ack_c >= 0) begin
                check("rr_ack", 32'(ack_o), 32'(4'b0001 << own));
                check("rr_resp", 32'(resp_out_o), 32'(16'hC000 + k));
            end
            ack_prev = ack_c;
            req_i[own] = 1'b0;
            tick();
            req_i[own] = 1'b1;
        end
        req_i = '0;
        wait_idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
